sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Receive-side counterpart of the bit splitter's parallel-in/serial-out stage.
- Collects a serial bit stream, delivered LSB-first one bit per qualified clock, back into WIDTH-bit words.
- Presents each completed word on a registered output with a valid/ready handshake.
- Sits after the QPSK demodulator's bit merger and feeds byte-wide consumers. Provides word alignment (sync) and sticky overrun detection.

Parameters:
- WIDTH, 8, word width in bits (must be at least 2).
- LSB_FIRST, 1: 1 means the first received bit lands in bit 0; 0 means the first received bit lands in bit WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled on this edge when high
- sync  input  1  word-alignment strobe: restarts the bit count
- dout  output  WIDTH  last completed word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when high with dout_valid high
- bit_cnt  output  clog2(WIDTH)  bits already collected in the current word
- overrun  output  1  sticky: a completed word was dropped
- clr_ovr  input  1  clears overrun

Behaviour:
- Reset: rst high at an edge sets the shift register, dout, dout_valid, bit_cnt and overrun all to 0. rst takes priority over every other input, including mid-word and while dout_valid is high.
- Shift:
  - On an edge with din_valid=1, din is placed into the shift register, and bit_cnt increments.
  - LSB_FIRST=1: right shift, din enters at bit WIDTH-1, so after WIDTH bits the first bit sits at bit 0.
  - LSB_FIRST=0: left shift, din enters at bit 0.
  - din_valid=0: shift register and bit_cnt hold.
- Completion:
  - The edge that samples bit number WIDTH (bit_cnt==WIDTH-1 with din_valid=1) is the completing edge. bit_cnt wraps to 0 on that edge.
  - The full word, including the bit sampled on that edge, transfers to dout on the same edge.
  - dout_valid rises on that edge, so it is seen in the cycle after the last bit.
  - Latency from last bit sampled to dout_valid: 1 clock.
- Output handshake:
  - dout_valid stays high and dout stays stable until an edge with dout_valid=1 and dout_ready=1.
  - On that edge dout_valid falls, unless a completing edge coincides.
  - dout_ready is ignored while dout_valid=0.
- Simultaneous accept and completion: the new word loads into dout, dout_valid stays 1, and no overrun is flagged.
- Overrun:
  - Occurs on a completing edge while dout_valid=1 and dout_ready=0.
  - The new word is dropped and dout keeps the old word.
  - overrun is set to 1 and bit_cnt still wraps to 0.
- overrun clear:
  - overrun clears on an edge with clr_ovr=1.
  - If a set condition occurs on the same edge, set wins and overrun stays 1.
- sync:
  - On an edge with sync=1, the partial word is discarded: the shift register is zeroed and bit_cnt goes to 0.
  - If din_valid=1 on the same edge, that din is taken as the first bit of the new word and bit_cnt becomes 1.
  - sync never affects dout, dout_valid or overrun.
  - sync on a would-be completing edge suppresses that completion.
- Hold behaviour: with no din_valid, bit_cnt, the partial word and all outputs hold indefinitely.

Test Plan:
- Reset clears state: rst for 2 clocks → dout=0x00, dout_valid=0, bit_cnt=0, overrun=0.
- Basic word, LSB_FIRST=1: feed bits 1,0,1,0,0,1,0,1 with din_valid=1 on consecutive clocks and dout_ready=1 → one cycle after the 8th bit, dout=0xA5 and dout_valid=1 for exactly one cycle.
- Gapped input and handshake: same bits with din_valid=0 gaps between them and dout_ready=0 → dout_valid rises after the 8th valid bit and holds 0xA5 until dout_ready is pulsed, then falls on the next edge.
- Back-to-back and overrun:
  - Stream 0x3C then 0xC3 continuously, dout_ready=1 on the completing edge of 0xC3 → no overrun, dout switches 0x3C→0xC3 with dout_valid staying 1.
  - Repeat with dout_ready=0 → dout stays 0x3C and overrun=1.
  - Pulse clr_ovr → overrun=0.
- Alignment: feed 3 garbage bits, then assert sync together with the first bit of 0x81 → bit_cnt=1 after that edge, and dout=0x81 after 7 more bits.
- Reset mid-word and LSB_FIRST=0:
  - Assert rst after 5 bits → bit_cnt=0 and no word is emitted from the partial data.
  - With LSB_FIRST=0, feed 1,0,0,0,0,0,0,0 → dout=0x80.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer: gathers a 1-bit stream into WIDTH-bit
// words and presents each on a registered valid/ready output. It also provides
// word alignment through sync and flags dropped words with a sticky overrun.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     sync,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     clr_ovr
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt_base;
  logic [CW-1:0]    cnt_next;
  logic             complete;
  logic             ovr_set;
  logic [WIDTH-1:0] dout_next;
  logic             dout_valid_next;
  logic             overrun_next;

  // Next shift-register and count; sync restarts the word before this edge's bit is taken
  always_comb begin
    sr_base  = sync ? '0 : sr_q;
    cnt_base = sync ? '0 : bit_cnt;
    sr_next  = sr_base;
    cnt_next = cnt_base;
    complete = 1'b0;
    if (din_valid) begin
      if (LSB_FIRST) begin
        sr_next = {din, sr_base[WIDTH-1:1]};
      end else begin
        sr_next = {sr_base[WIDTH-2:0], din};
      end
      // A sync on this edge means cnt_base is zero, so it can never complete
      if (cnt_base == LAST_CNT) begin
        complete = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_base + CW'(1);
      end
    end
  end

  // Output handshake: load on completion unless an unaccepted word is still held
  always_comb begin
    dout_next       = dout;
    dout_valid_next = dout_valid;
    ovr_set         = 1'b0;
    if (complete && (!dout_valid || dout_ready)) begin
      dout_next       = sr_next;
      dout_valid_next = 1'b1;
    end else if (complete) begin
      ovr_set = 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid_next = 1'b0;
    end
    // A new overrun on the same edge as a clear leaves the flag set
    if (ovr_set) begin
      overrun_next = 1'b1;
    end else if (clr_ovr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sr_q       <= sr_next;
      bit_cnt    <= cnt_next;
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      overrun    <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed vector bench for sipo_deserializer (LSB-first instance checked by
// table, MSB-first instance checked by a hand-written sequence).
module tb_sipo_deserializer;

  typedef struct {
    logic       r, d, v, s, rdy, clr;
    logic [7:0] e_dout;
    logic       e_dv;
    logic [2:0] e_cnt;
    logic       e_ovr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, sync, dout_ready, clr_ovr;
  logic [7:0] dout, dout0;
  logic       dout_valid, dout_valid0, overrun, overrun0;
  logic [2:0] bit_cnt, bit_cnt0;

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt0), .overrun(overrun0), .clr_ovr(clr_ovr)
  );

  // Append one vector: inputs for the edge, expected outputs just after it
  function automatic void add(logic r, logic d, logic v, logic s, logic rdy, logic clr,
                              logic [7:0] e_dout, logic e_dv, logic [2:0] e_cnt, logic e_ovr);
    vec_t t;
    t.r = r; t.d = d; t.v = v; t.s = s; t.rdy = rdy; t.clr = clr;
    t.e_dout = e_dout; t.e_dv = e_dv; t.e_cnt = e_cnt; t.e_ovr = e_ovr;
    vq.push_back(t);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;

    // Reset
    add(1,0,0,0,0,0, 8'h00,0,3'd0,0);
    add(1,0,0,0,0,0, 8'h00,0,3'd0,0);

    // Basic word, ready held high: valid for exactly one cycle
    w = 8'hA5;
    for (int k = 0; k < 7; k++) add(0,w[k],1,0,1,0, 8'h00,0,3'(k+1),0);
    add(0,w[7],1,0,1,0, 8'hA5,1,3'd0,0);
    add(0,0,0,0,1,0, 8'hA5,0,3'd0,0);
    add(0,0,0,0,1,0, 8'hA5,0,3'd0,0);

    // Gapped input, ready low until a single pulse
    for (int k = 0; k < 7; k++) begin
      add(0,w[k],1,0,0,0, 8'hA5,0,3'(k+1),0);
      add(0,1,0,0,0,0, 8'hA5,0,3'(k+1),0);
    end
    add(0,w[7],1,0,0,0, 8'hA5,1,3'd0,0);
    add(0,0,0,0,0,0, 8'hA5,1,3'd0,0);
    add(0,0,0,0,0,0, 8'hA5,1,3'd0,0);
    add(0,0,0,0,1,0, 8'hA5,0,3'd0,0);

    // Back-to-back 3C then C3, accepted on the completing edge
    w = 8'h3C; w2 = 8'hC3;
    for (int k = 0; k < 7; k++) add(0,w[k],1,0,0,0, 8'hA5,0,3'(k+1),0);
    add(0,w[7],1,0,0,0, 8'h3C,1,3'd0,0);
    for (int k = 0; k < 7; k++) add(0,w2[k],1,0,0,0, 8'h3C,1,3'(k+1),0);
    add(0,w2[7],1,0,1,0, 8'hC3,1,3'd0,0);
    add(0,0,0,0,1,0, 8'hC3,0,3'd0,0);

    // Same stream with ready low: overrun, then clear
    for (int k = 0; k < 7; k++) add(0,w[k],1,0,0,0, 8'hC3,0,3'(k+1),0);
    add(0,w[7],1,0,0,0, 8'h3C,1,3'd0,0);
    for (int k = 0; k < 7; k++) add(0,w2[k],1,0,0,0, 8'h3C,1,3'(k+1),0);
    add(0,w2[7],1,0,0,0, 8'h3C,1,3'd0,1);
    add(0,0,0,0,0,0, 8'h3C,1,3'd0,1);
    add(0,0,0,0,0,1, 8'h3C,1,3'd0,0);
    add(0,0,0,0,1,0, 8'h3C,0,3'd0,0);

    // Alignment: three garbage bits, then sync with the first bit of 0x81
    w = 8'h81;
    for (int k = 0; k < 3; k++) add(0,1,1,0,1,0, 8'h3C,0,3'(k+1),0);
    add(0,w[0],1,1,1,0, 8'h3C,0,3'd1,0);
    for (int k = 1; k < 7; k++) add(0,w[k],1,0,1,0, 8'h3C,0,3'(k+1),0);
    add(0,w[7],1,0,1,0, 8'h81,1,3'd0,0);
    add(0,0,0,0,0,0, 8'h81,1,3'd0,0);

    // Sync on a would-be completing edge: no completion, no overrun
    for (int k = 0; k < 7; k++) add(0,1,1,0,0,0, 8'h81,1,3'(k+1),0);
    add(0,1,1,1,0,0, 8'h81,1,3'd1,0);
    add(0,0,0,1,0,0, 8'h81,1,3'd0,0);
    add(0,0,0,0,1,0, 8'h81,0,3'd0,0);

    // Reset mid-word discards the partial data
    for (int k = 0; k < 5; k++) add(0,1,1,0,0,0, 8'h81,0,3'(k+1),0);
    add(1,1,1,0,1,0, 8'h00,0,3'd0,0);
    add(0,0,0,0,0,0, 8'h00,0,3'd0,0);
    add(0,0,0,0,0,0, 8'h00,0,3'd0,0);

    // Apply table
    foreach (vq[i]) begin
      rst = vq[i].r; din = vq[i].d; din_valid = vq[i].v; sync = vq[i].s;
      dout_ready = vq[i].rdy; clr_ovr = vq[i].clr;
      @(posedge clk); #1;
      check($sformatf("vec%0d {dout,dv,cnt,ovr}", i),
            32'({dout, dout_valid, bit_cnt, overrun}),
            32'({vq[i].e_dout, vq[i].e_dv, vq[i].e_cnt, vq[i].e_ovr}));
    end

    // MSB-first instance: bits 1,0,0,0,0,0,0,0 give 0x80 (0x01 on the LSB-first one)
    rst = 0; sync = 0; clr_ovr = 0; dout_ready = 0; din_valid = 1;
    for (int k = 0; k < 8; k++) begin
      din = (k == 0);
      @(posedge clk); #1;
      if (k == 2) check("msb_first bit_cnt", 32'(bit_cnt0), 32'd3);
    end
    din_valid = 0;
    check("msb_first dout", 32'(dout0), 32'h80);
    check("msb_first dout_valid", 32'(dout_valid0), 32'd1);
    check("lsb_first dout same bits", 32'(dout), 32'h01);
    check("bit_cnt wrapped", 32'(bit_cnt0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
